// File: rtl/adler_pkg.sv
// rtl/adler_pkg.sv - shared types and constants for the Adler-32 sequencer
//
// Purpose : FSM state type, default modulus and initial A value used by
//           adler_sequencer and mod_reduce.
// Ports   : none (package).

package adler_pkg;

  // Largest prime below 2^16; the standard Adler-32 modulus.
  localparam int unsigned ADLER_MOD_BASE = 65521;

  // Running sum A starts at 1 so that leading zero bytes still change B.
  localparam logic [15:0] ADLER_INIT_A = 16'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_UPD_A,
    ST_UPD_B,
    ST_DONE
  } adler_state_t;

endpackage

// File: rtl/mod_reduce.sv
// rtl/mod_reduce.sv - single conditional subtract modulo reduction
//
// Purpose : maps a 17-bit sum of two values below MOD_BASE (or a value
//           below MOD_BASE plus a byte) back into [0, MOD_BASE).
// Ports   : sum_in  [16:0] unreduced sum
//           sum_out [15:0] sum_in mod MOD_BASE

module mod_reduce
  import adler_pkg::*;
#(
  parameter int unsigned MOD_BASE = ADLER_MOD_BASE
) (
  input  logic [16:0] sum_in,
  output logic [15:0] sum_out
);

  localparam logic [16:0] MOD17 = 17'(MOD_BASE);

  // Both addends are below MOD_BASE, so the sum is below 2*MOD_BASE and one
  // subtraction always suffices. The result fits in 16 bits either way.
  always_comb begin
    if (sum_in >= MOD17) begin
      sum_out = 16'(sum_in - MOD17);
    end else begin
      sum_out = 16'(sum_in);
    end
  end

endmodule

// File: rtl/adler_sequencer.sv
// rtl/adler_sequencer.sv - byte-serial Adler-32 checksum sequencer
//
// Purpose : accepts one message byte per handshake and folds it into the
//           running Adler sums A and B over two update cycles that share a
//           single modulo reducer. On the last byte the result is published
//           on checksum together with a one-cycle done pulse.
// Build   : define ADLER_BYTE_COUNT_EN to add the byte_count output.
// Ports   : clk        clock, rising edge
//           rst_n      asynchronous active-low reset
//           start      begin a new message (acted on only in IDLE)
//           data_valid data_in/last valid this cycle
//           data_in    [7:0] message byte
//           last       final byte of the message, qualified by data_valid
//           data_ready byte is accepted this cycle (ACCEPT only)
//           busy       high in every state except IDLE
//           done       one-cycle pulse when checksum is updated
//           checksum   [31:0] {B, A} of the last completed message
//           byte_count [31:0] bytes accepted since start (optional)

module adler_sequencer
  import adler_pkg::*;
#(
  parameter int unsigned MOD_BASE = ADLER_MOD_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  input  logic        last,
  output logic        data_ready,
  output logic        busy,
  output logic        done,
`ifdef ADLER_BYTE_COUNT_EN
  output logic [31:0] byte_count,
`endif
  output logic [31:0] checksum
);

  adler_state_t state;
  logic [15:0]  sum_a;
  logic [15:0]  sum_b;
  logic [7:0]   byte_hold;
  logic         last_hold;

  logic [16:0]  red_in;
  logic [15:0]  red_out;

  // One reducer serves both update cycles: UPD_A folds the byte into A,
  // UPD_B folds the freshly updated A into B.
  always_comb begin
    red_in = {1'b0, sum_a} + {9'b0, byte_hold};
    if (state == ST_UPD_B) begin
      red_in = {1'b0, sum_b} + {1'b0, sum_a};
    end
  end

  mod_reduce #(
    .MOD_BASE (MOD_BASE)
  ) u_reduce (
    .sum_in  (red_in),
    .sum_out (red_out)
  );

  // data_ready, busy and done are registered alongside the state so they
  // always reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sum_a      <= ADLER_INIT_A;
      sum_b      <= 16'd0;
      byte_hold  <= 8'd0;
      last_hold  <= 1'b0;
      checksum   <= 32'd0;
      done       <= 1'b0;
      busy       <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sum_a      <= ADLER_INIT_A;
            sum_b      <= 16'd0;
            state      <= ST_ACCEPT;
            busy       <= 1'b1;
            data_ready <= 1'b1;
          end
        end
        ST_ACCEPT: begin
          if (data_valid) begin
            byte_hold  <= data_in;
            last_hold  <= last;
            state      <= ST_UPD_A;
            data_ready <= 1'b0;
          end
        end
        ST_UPD_A: begin
          sum_a <= red_out;
          state <= ST_UPD_B;
        end
        ST_UPD_B: begin
          sum_b <= red_out;
          if (last_hold) begin
            // Publish with the new B directly so checksum and done appear
            // together in the DONE cycle.
            checksum <= {red_out, sum_a};
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            data_ready <= 1'b1;
            state      <= ST_ACCEPT;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy       <= 1'b0;
          data_ready <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ADLER_BYTE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count <= 32'd0;
    end else if (state == ST_IDLE && start) begin
      byte_count <= 32'd0;
    end else if (state == ST_ACCEPT && data_valid) begin
      byte_count <= byte_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adler_sequencer.sv
// tb/tb_adler_sequencer.sv - self-checking bench for adler_sequencer

module tb_adler_sequencer;

  localparam int unsigned MOD = 65521;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        data_valid = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        last = 1'b0;
  logic        data_ready;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
`ifdef ADLER_BYTE_COUNT_EN
  logic [31:0] byte_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  adler_sequencer #(
    .MOD_BASE (MOD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_valid (data_valid),
    .data_in    (data_in),
    .last       (last),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done),
`ifdef ADLER_BYTE_COUNT_EN
    .byte_count (byte_count),
`endif
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] adler_ref(input byte_q_t m);
    int unsigned a;
    int unsigned b;
    a = 1;
    b = 0;
    foreach (m[k]) begin
      a = (a + m[k]) % MOD;
      b = (b + a) % MOD;
    end
    return {b[15:0], a[15:0]};
  endfunction

  task automatic run_msg(input string name, input byte_q_t msg, input bit hold_valid, input bit gaps);
    logic [31:0] exp;
    logic [31:0] prev;
    int i;
    int budget;
    bit go;
    exp = adler_ref(msg);
    prev = checksum;
    @(negedge clk);
    start = 1'b1;
    if (hold_valid) begin
      data_valid = 1'b1;
      data_in = 8'($urandom);
      last = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || data_ready !== 1'b1)
      $display("FAIL %s accept_entry: busy=%b ready=%b want 1/1", name, busy, data_ready);
    else pass_cnt++;
    total_cnt++;
    if (checksum !== prev)
      $display("FAIL %s checksum_hold: got %h want %h", name, checksum, prev);
    else pass_cnt++;
`ifdef ADLER_BYTE_COUNT_EN
    total_cnt++;
    if (byte_count !== 32'd0)
      $display("FAIL %s count_clear: got %0d want 0", name, byte_count);
    else pass_cnt++;
`endif
    i = 0;
    budget = 0;
    while (i < msg.size() && budget < 5000) begin
      budget++;
      go = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!go) begin
        data_valid = 1'b0;
        data_in = 8'($urandom);
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (data_ready !== 1'b1 || busy !== 1'b1)
          $display("FAIL %s gap_stay: ready=%b busy=%b want 1/1", name, data_ready, busy);
        else pass_cnt++;
        continue;
      end
      data_valid = 1'b1;
      data_in = msg[i];
      last = (i == msg.size() - 1);
      @(negedge clk);
      if (hold_valid) begin
        data_in = 8'($urandom);
        last = 1'($urandom_range(0, 1));
      end else begin
        data_valid = 1'b0;
      end
      total_cnt++;
      if (data_ready !== 1'b0 || done !== 1'b0)
        $display("FAIL %s upd_a: ready=%b done=%b want 0/0", name, data_ready, done);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (data_ready !== 1'b0 || done !== 1'b0)
        $display("FAIL %s upd_b: ready=%b done=%b want 0/0", name, data_ready, done);
      else pass_cnt++;
      @(negedge clk);
      if (i == msg.size() - 1) begin
        total_cnt++;
        if (done !== 1'b1)
          $display("FAIL %s done_pulse: got %b want 1", name, done);
        else pass_cnt++;
        total_cnt++;
        if (checksum !== exp)
          $display("FAIL %s checksum: got %h want %h", name, checksum, exp);
        else pass_cnt++;
`ifdef ADLER_BYTE_COUNT_EN
        total_cnt++;
        if (byte_count !== 32'(msg.size()))
          $display("FAIL %s byte_count: got %0d want %0d", name, byte_count, msg.size());
        else pass_cnt++;
`endif
      end else begin
        total_cnt++;
        if (data_ready !== 1'b1 || done !== 1'b0)
          $display("FAIL %s next_accept: ready=%b done=%b want 1/0", name, data_ready, done);
        else pass_cnt++;
      end
      i++;
    end
    data_valid = 1'b0;
    last = 1'b0;
    if (i < msg.size()) begin
      total_cnt++;
      $display("FAIL %s timeout: consumed %0d want %0d", name, i, msg.size());
    end
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s idle_return: done=%b busy=%b want 0/0", name, done, busy);
    else pass_cnt++;
    total_cnt++;
    if (checksum !== exp)
      $display("FAIL %s checksum_after: got %h want %h", name, checksum, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || data_ready !== 1'b0 || done !== 1'b0 || checksum !== 32'd0)
      $display("FAIL reset_values: busy=%b ready=%b done=%b sum=%h want 0/0/0/0",
               busy, data_ready, done, checksum);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || data_ready !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b ready=%b want 0/0", busy, data_ready);
    else pass_cnt++;
  endtask

  task automatic test_single();
    byte_q_t m;
    m = '{8'h61};
    run_msg("single", m, 1'b0, 1'b0);
    total_cnt++;
    if (checksum !== 32'h00620062)
      $display("FAIL single_const: got %h want 00620062", checksum);
    else pass_cnt++;
  endtask

  task automatic test_abc();
    byte_q_t m;
    m = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", m, 1'b0, 1'b0);
    total_cnt++;
    if (checksum !== 32'h024D0127)
      $display("FAIL abc_const: got %h want 024d0127", checksum);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    byte_q_t m;
    repeat (300) m.push_back(8'hFF);
    run_msg("wrap300", m, 1'b0, 1'b0);
    total_cnt++;
    if (checksum !== 32'hB90F2AE4)
      $display("FAIL wrap_const: got %h want b90f2ae4", checksum);
    else pass_cnt++;
  endtask

  task automatic test_hold_valid();
    byte_q_t m;
    for (int n = 0; n < 3; n++) begin
      m.delete();
      repeat ($urandom_range(1, 20)) m.push_back(8'($urandom));
      run_msg("hold_valid", m, 1'b1, 1'b0);
    end
  endtask

  task automatic test_gaps();
    byte_q_t m;
    for (int n = 0; n < 3; n++) begin
      m.delete();
      repeat ($urandom_range(1, 20)) m.push_back(8'($urandom));
      run_msg("gaps", m, 1'b0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t m;
    for (int n = 0; n < 4; n++) begin
      m.delete();
      repeat ($urandom_range(1, 8)) m.push_back(8'($urandom_range(200, 255)));
      run_msg("back_to_back", m, n[0], 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t m;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_valid = 1'b1;
    data_in = 8'h12;
    last = 1'b0;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || data_ready !== 1'b0 || done !== 1'b0 || checksum !== 32'd0)
      $display("FAIL reset_mid: busy=%b ready=%b done=%b sum=%h want 0/0/0/0",
               busy, data_ready, done, checksum);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    m = '{8'h61, 8'h62, 8'h63};
    run_msg("after_reset", m, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_abc();
    test_wrap();
    test_hold_valid();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
